// File: rtl/col_pwm_driver_pkg.sv
// rtl/col_pwm_driver_pkg.sv - shared state encoding and default geometry for the column PWM driver
package col_pwm_driver_pkg;

    localparam int NCOL_DEF         = 8;
    localparam int DUTY_WIDTH_DEF   = 8;
    localparam int BLANK_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_e;

endpackage

// File: rtl/col_pwm_driver_if.sv
// rtl/col_pwm_driver_if.sv - column advance, duty write and column drive signals
interface col_pwm_driver_if
    import col_pwm_driver_pkg::*;
#(
    parameter int NCOL       = NCOL_DEF,
    parameter int DUTY_WIDTH = DUTY_WIDTH_DEF
);
    localparam int COL_W = $clog2(NCOL);

    logic                  ce;
    logic [COL_W-1:0]      col;
    logic                  we;
    logic [COL_W-1:0]      waddr;
    logic [DUTY_WIDTH-1:0] wdata;
    logic [NCOL-1:0]       col_out;
    logic                  busy;
    logic                  ceo;

    modport master (
        output ce, col, we, waddr, wdata,
        input  col_out, busy, ceo
    );

    modport slave (
        input  ce, col, we, waddr, wdata,
        output col_out, busy, ceo
    );

endinterface

// File: rtl/col_pwm_driver_duty_regfile.sv
// rtl/col_pwm_driver_duty_regfile.sv - per-column duty registers, one sync write and one comb read port
module duty_regfile #(
    parameter int NCOL       = 8,
    parameter int DUTY_WIDTH = 8,
    localparam int AW        = $clog2(NCOL)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DUTY_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DUTY_WIDTH-1:0] rdata_o
);

    logic [DUTY_WIDTH-1:0] mem_q [NCOL];

    // Address decode by comparison so out-of-range addresses hit nothing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCOL; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCOL; i++) begin
                if (we_i && (waddr_i == AW'(i))) mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (raddr_i == AW'(i)) rdata_o = mem_q[i];
        end
    end

endmodule

// File: rtl/col_pwm_driver.sv
// rtl/col_pwm_driver.sv - blank/ON sequencer driving one PWM-modulated one-hot column per period
module col_pwm_driver
    import col_pwm_driver_pkg::*;
#(
    parameter int NCOL         = NCOL_DEF,
    parameter int DUTY_WIDTH   = DUTY_WIDTH_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    col_pwm_driver_if.slave        bus
);

    localparam int COL_W   = $clog2(NCOL);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

    state_e                state_q, state_d;
    logic [BLANK_W-1:0]    blank_cnt_q, blank_cnt_d;
    logic [DUTY_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [COL_W-1:0]      col_r_q, col_r_d;
    logic [DUTY_WIDTH-1:0] duty_r_q, duty_r_d;
    logic                  ceo_q, ceo_d;
    logic [DUTY_WIDTH-1:0] duty_rd;

    duty_regfile #(
        .NCOL       (NCOL),
        .DUTY_WIDTH (DUTY_WIDTH)
    ) u_duty (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (bus.we),
        .waddr_i (bus.waddr),
        .wdata_i (bus.wdata),
        .raddr_i (bus.col),
        .rdata_o (duty_rd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            blank_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            col_r_q     <= '0;
            duty_r_q    <= '0;
            ceo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            col_r_q     <= col_r_d;
            duty_r_q    <= duty_r_d;
            ceo_q       <= ceo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        col_r_d     = col_r_q;
        duty_r_d    = duty_r_q;
        ceo_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Regfile read is pre-edge, so a same-edge write to this column is not seen.
                if (bus.ce) begin
                    col_r_d     = bus.col;
                    duty_r_d    = duty_rd;
                    blank_cnt_d = '0;
                    state_d     = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_W'(BLANK_CYCLES - 1)) begin
                    pwm_cnt_d = '0;
                    state_d   = ST_ON;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
                if (pwm_cnt_q == '1) begin
                    state_d = ST_IDLE;
                    ceo_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded purely from registers so the BLANK->ON transition cannot glitch.
    always_comb begin
        bus.col_out = '0;
        for (int i = 0; i < NCOL; i++) begin
            bus.col_out[i] = (state_q == ST_ON) && (col_r_q == COL_W'(i)) &&
                             (pwm_cnt_q < duty_r_q);
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.ceo  = ceo_q;

endmodule

// File: tb/tb_col_pwm_driver.sv
// tb/tb_col_pwm_driver.sv - directed self-checking bench for col_pwm_driver
module tb_col_pwm_driver;
    import col_pwm_driver_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    col_pwm_driver_if #(.NCOL(8), .DUTY_WIDTH(8)) bus ();

    col_pwm_driver #(.NCOL(8), .DUTY_WIDTH(8), .BLANK_CYCLES(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input logic [2:0] a, input logic [7:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        step();
        bus.we = 1'b0;
    endtask

    // Edge 0 accepts CE; checks cycles 1..261 and returns sitting in the CEO cycle.
    task automatic run_period(input string tag, input logic [2:0] col, input int duty,
                              input bit hold_ce, input bit do_we, input logic [2:0] wa,
                              input logic [7:0] wd, input int mid_c, input logic [7:0] mid_wd);
        logic [7:0] onehot;
        logic [7:0] exp_out;
        onehot = 8'h01 << col;
        bus.ce = 1'b1; bus.col = col;
        bus.we = do_we; bus.waddr = wa; bus.wdata = wd;
        step();
        bus.we = 1'b0;
        for (int c = 1; c <= 261; c++) begin
            exp_out = (c >= 5 && c < 5 + duty) ? onehot : 8'h00;
            check($sformatf("%s c%0d col_out", tag, c), 32'(bus.col_out), 32'(exp_out));
            check($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(c <= 260));
            check($sformatf("%s c%0d ceo", tag, c), 32'(bus.ceo), 32'(c == 261));
            bus.ce    = hold_ce && (c < 261);
            bus.col   = hold_ce ? (col ^ 3'd1) : col;
            bus.we    = (c == mid_c);
            bus.waddr = col;
            bus.wdata = mid_wd;
            if (c < 261) step();
        end
        bus.ce = 1'b0; bus.we = 1'b0;
    endtask

    initial begin
        bus.ce = 1'b0; bus.col = '0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        step();
        step();
        check("reset col_out", 32'(bus.col_out), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset ceo", 32'(bus.ceo), 32'h0);
        rst = 1'b0;
        step();

        write_duty(3'd3, 8'd64);
        run_period("t2_col3_d64", 3'd3, 64, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        step();

        write_duty(3'd0, 8'd0);
        write_duty(3'd7, 8'd255);
        run_period("t3_col0_d0", 3'd0, 0, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        run_period("t3_col7_d255", 3'd7, 255, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        step();

        write_duty(3'd4, 8'd30);
        write_duty(3'd6, 8'd50);
        run_period("t4_hold_ce", 3'd6, 50, 1'b1, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        run_period("t4_b2b_col4", 3'd4, 30, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        step();

        write_duty(3'd2, 8'd10);
        run_period("t5_same_cycle", 3'd2, 10, 1'b0, 1'b1, 3'd2, 8'd200, -1, 8'd0);
        step();
        run_period("t5_new_duty", 3'd2, 200, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        step();

        write_duty(3'd5, 8'd100);
        run_period("t6_mid_write", 3'd5, 100, 1'b0, 1'b0, 3'd0, 8'd0, 20, 8'd0);
        step();
        run_period("t6_zero", 3'd5, 0, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        step();

        write_duty(3'd1, 8'd128);
        bus.ce = 1'b1; bus.col = 3'd1;
        step();
        bus.ce = 1'b0;
        for (int c = 1; c < 50; c++) step();
        check("t1 pre-reset col_out", 32'(bus.col_out), 32'h02);
        check("t1 pre-reset busy", 32'(bus.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t1 async col_out", 32'(bus.col_out), 32'h0);
        check("t1 async busy", 32'(bus.busy), 32'h0);
        check("t1 async ceo", 32'(bus.ceo), 32'h0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            check($sformatf("t1 post c%0d ceo", c), 32'(bus.ceo), 32'h0);
            check($sformatf("t1 post c%0d busy", c), 32'(bus.busy), 32'h0);
            step();
        end
        run_period("t1_clean_d0", 3'd1, 0, 1'b0, 1'b0, 3'd0, 8'd0, -1, 8'd0);
        step();
        check("t1 idle after", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
